// File: rtl/bram_stream_pkg.sv
// Shared types and sizing helpers for the difftest BRAM packet-buffer streamer.
// Read-side FSM encoding plus beat-count math used by the controller and serializer.
package bram_stream_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_LOAD   = 2'd2;
    localparam logic [1:0] ST_STREAM = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        FETCH  = ST_FETCH,
        LOAD   = ST_LOAD,
        STREAM = ST_STREAM
    } state_e;

    function automatic int beats_f(input int data_width, input int beat_width);
        return (data_width + beat_width - 1) / beat_width;
    endfunction

    // A single-beat packet still needs a 1-bit index so the ports stay legal.
    function automatic int beat_idx_w_f(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/bram_beat_serializer.sv
// Holds one fetched packet and presents it as BEAT_WIDTH beats on a valid/ready port.
// valid/ready: a beat transfers on any edge where out_valid && out_ready; data is held until then.
module bram_beat_serializer
    import bram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 4000,
    parameter int BEAT_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [BEAT_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  retire
);

    localparam int BEATS  = beats_f(DATA_WIDTH, BEAT_WIDTH);
    localparam int IDX_W  = beat_idx_w_f(BEATS);
    localparam int HOLD_W = BEATS * BEAT_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]  beat_idx_q, beat_idx_d;
    logic              valid_q, valid_d;
    logic              handshake;
    logic              at_last;

    assign at_last   = (beat_idx_q == LAST_IDX);
    assign handshake = valid_q && out_ready;
    assign retire    = handshake && at_last;

    assign out_valid = valid_q;
    assign out_last  = valid_q && at_last;
    assign out_data  = hold_q[int'(beat_idx_q) * BEAT_WIDTH +: BEAT_WIDTH];

    always_comb begin
        hold_d     = hold_q;
        beat_idx_d = beat_idx_q;
        valid_d    = valid_q;
        if (load) begin
            // Pad bits above DATA_WIDTH stay zero so the last beat is clean.
            hold_d                  = '0;
            hold_d[DATA_WIDTH-1:0]  = load_data;
            beat_idx_d              = '0;
            valid_d                 = 1'b1;
        end else if (handshake) begin
            if (at_last) begin
                valid_d    = 1'b0;
                beat_idx_d = '0;
            end else begin
                beat_idx_d = beat_idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            beat_idx_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            beat_idx_q <= beat_idx_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: rtl/bram_stream_ctrl.sv
// Packet-buffer controller: writes difftest packets into an external BRAM and
// streams the oldest entry out as beats toward the host transport.
module bram_stream_ctrl
    import bram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 4000,
    parameter int ADDR_WIDTH = 3,
    parameter int BEAT_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  bram_en,
    output logic                  bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_waddr,
    output logic [ADDR_WIDTH-1:0] bram_raddr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BEAT_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH_I = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH = DEPTH_I[ADDR_WIDTH:0];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  in_ready_q, in_ready_d;
    logic                  push;
    logic                  retire;
    logic                  load;

    assign push = in_valid && in_ready_q;
    assign load = (state_q == LOAD);

    assign in_ready   = in_ready_q;
    assign count      = count_q;
    assign bram_en    = push || (state_q == FETCH);
    assign bram_wea   = push;
    assign bram_waddr = wr_ptr_q;
    assign bram_wdata = in_data;
    assign bram_raddr = rd_ptr_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (retire) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        case ({push, retire})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
        in_ready_d = (count_d != DEPTH);

        case (state_q)
            IDLE:    if (count_q != '0) state_d = FETCH;
            FETCH:   state_d = LOAD;
            LOAD:    state_d = STREAM;
            // A push landing on the retire edge keeps the pipeline going.
            STREAM:  if (retire) state_d = (count_d != '0) ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    bram_beat_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH)
    ) u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (bram_rdata),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .retire    (retire)
    );

endmodule
